// File: rtl/i2s_clk_ctrl.sv
// I2S serial clock / word select sequencer with a runtime divide ratio and channel width.
// Frames start and stop on whole-frame boundaries; config changes apply only at frame end.
module i2s_clk_ctrl #(
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned HALF_W       = 6,
  parameter int unsigned DEFAULT_DIV  = 9,
  parameter int unsigned DEFAULT_HALF = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [DIV_W-1:0]  i_cfg_div,
  input  logic [HALF_W-1:0] i_cfg_half,
  output logic              o_sck,
  output logic              o_sck_rise,
  output logic              o_sck_fall,
  output logic              o_ws,
  output logic              o_frame_start,
  output logic              o_busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

  state_t              r_state, w_state_d;
  logic [DIV_W-1:0]    r_cnt, w_cnt_d;
  logic                r_sck, w_sck_d;
  logic                r_ws, w_ws_d;
  logic [HALF_W-1:0]   r_bit, w_bit_d;
  logic                r_rise, w_rise_d;
  logic                r_fall, w_fall_d;
  logic                r_fs, w_fs_d;
  logic                r_end, w_end_d;
  logic [DIV_W-1:0]    r_div, r_sh_div;
  logic [HALF_W-1:0]   r_half, r_sh_half;
  logic                r_pend;

  logic [DIV_W-1:0]    w_div_in, w_rise_div, w_hi_m1, w_lo_m1;
  logic [HALF_W-1:0]   w_half_in;
  logic                w_hs, w_apply, w_last_bit;

  assign w_div_in   = (i_cfg_div < DIV_W'(2)) ? DIV_W'(2) : i_cfg_div;
  assign w_half_in  = (i_cfg_half == '0) ? HALF_W'(1) : i_cfg_half;
  assign w_hs       = i_cfg_valid & ~r_pend;
  assign w_apply    = r_end & r_pend;
  // The divide ratio that governs the next rise, including a config landing this cycle.
  assign w_rise_div = (w_hs && (r_state == StIdle)) ? w_div_in :
                      w_apply                       ? r_sh_div : r_div;
  assign w_hi_m1    = (w_rise_div - DIV_W'(1)) >> 1;
  assign w_lo_m1    = (r_div >> 1) - DIV_W'(1);
  assign w_last_bit = (r_bit == (r_half - HALF_W'(1)));

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_sck_d   = r_sck;
    w_ws_d    = r_ws;
    w_bit_d   = r_bit;
    w_rise_d  = 1'b0;
    w_fall_d  = 1'b0;
    w_fs_d    = 1'b0;
    w_end_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_sck_d = 1'b0;
        w_ws_d  = 1'b0;
        w_bit_d = '0;
        if (i_en) begin
          w_state_d = StRun;
          w_sck_d   = 1'b1;
          w_rise_d  = 1'b1;
          w_fs_d    = 1'b1;
          w_cnt_d   = w_hi_m1;
        end
      end
      StRun, StDrain: begin
        if (r_state == StRun && !i_en) w_state_d = StDrain;
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - DIV_W'(1);
        end else if (r_sck) begin
          w_sck_d  = 1'b0;
          w_fall_d = 1'b1;
          w_cnt_d  = w_lo_m1;
          if (w_last_bit) begin
            w_bit_d = '0;
            w_ws_d  = ~r_ws;
            if (r_ws) begin
              w_end_d = 1'b1;
              if (r_state == StDrain || !i_en) w_state_d = StIdle;
            end
          end else begin
            w_bit_d = r_bit + HALF_W'(1);
          end
        end else begin
          w_sck_d  = 1'b1;
          w_rise_d = 1'b1;
          w_fs_d   = ~r_ws & (r_bit == '0);
          w_cnt_d  = w_hi_m1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_bit     <= '0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_fs      <= 1'b0;
      r_end     <= 1'b0;
      r_div     <= DIV_W'(DEFAULT_DIV);
      r_half    <= HALF_W'(DEFAULT_HALF);
      r_sh_div  <= DIV_W'(DEFAULT_DIV);
      r_sh_half <= HALF_W'(DEFAULT_HALF);
      r_pend    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_sck   <= w_sck_d;
      r_ws    <= w_ws_d;
      r_bit   <= w_bit_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
      r_fs    <= w_fs_d;
      r_end   <= w_end_d;
      if (w_hs && r_state == StIdle) begin
        r_div  <= w_div_in;
        r_half <= w_half_in;
      end else if (w_apply) begin
        r_div  <= r_sh_div;
        r_half <= r_sh_half;
        r_pend <= 1'b0;
      end
      if (w_hs && r_state != StIdle) begin
        r_sh_div  <= w_div_in;
        r_sh_half <= w_half_in;
        r_pend    <= 1'b1;
      end
    end
  end

  assign o_cfg_ready   = ~r_pend;
  assign o_sck         = r_sck;
  assign o_sck_rise    = r_rise;
  assign o_sck_fall    = r_fall;
  assign o_ws          = r_ws;
  assign o_frame_start = r_fs;
  assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Directed bench for i2s_clk_ctrl; expected waveforms come from a closed-form timing model.
module tb_i2s_clk_ctrl;

  logic       clk = 1'b0;
  logic       reset, en, cfg_valid, cfg_ready;
  logic [7:0] cfg_div;
  logic [5:0] cfg_half;
  logic       sck, sck_rise, sck_fall, ws, frame_start, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2s_clk_ctrl dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_en          (en),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_ready   (cfg_ready),
    .i_cfg_div     (cfg_div),
    .i_cfg_half    (cfg_half),
    .o_sck         (sck),
    .o_sck_rise    (sck_rise),
    .o_sck_fall    (sck_fall),
    .o_ws          (ws),
    .o_frame_start (frame_start),
    .o_busy        (busy)
  );

  // {cfg_ready, sck, sck_rise, sck_fall, ws, frame_start, busy}
  logic [6:0] obs;
  assign obs = {cfg_ready, sck, sck_rise, sck_fall, ws, frame_start, busy};

  // k = clk cycles since the first rise of a run of period d, n bits per channel
  function automatic logic [6:0] model(int d, int n, int k, bit rdy, bit bsy);
    int h, ph, falls;
    h     = (d + 1) / 2;
    ph    = k % d;
    falls = (k / d) + ((ph >= h) ? 1 : 0);
    return {rdy, (ph < h), (ph == 0), (ph == h), (((falls / n) % 2) == 1),
            ((k % (2 * n * d)) == 0), bsy};
  endfunction

  task automatic do_reset();
    reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_half = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic offer_cfg(input logic [7:0] d, input logic [5:0] n);
    cfg_valid = 1'b1; cfg_div = d; cfg_half = n;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_half = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b1000000) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs, 7'b1000000);
      end
    end
    reset = 1'b1; en = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=%b", obs, 7'b1000000);
    end
  endtask

  task automatic test_defaults();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model(9, 16, k, 1'b1, 1'b1)) begin
        failures++;
        $display("FAIL defaults k=%0d got=%b exp=%b", k, obs, model(9, 16, k, 1'b1, 1'b1));
      end
    end
  endtask

  task automatic test_min_cfg();
    do_reset();
    offer_cfg(8'd2, 6'd1);
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model(2, 1, k, 1'b1, 1'b1)) begin
        failures++;
        $display("FAIL min_cfg k=%0d got=%b exp=%b", k, obs, model(2, 1, k, 1'b1, 1'b1));
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] dv [2];
    dv[0] = 8'd0;
    dv[1] = 8'd1;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      offer_cfg(dv[t], 6'd0);
      en = 1'b1;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        checks++;
        if (obs !== model(2, 1, k, 1'b1, 1'b1)) begin
          failures++;
          $display("FAIL clamp div=%0d k=%0d got=%b exp=%b", dv[t], k, obs,
                   model(2, 1, k, 1'b1, 1'b1));
        end
      end
    end
  endtask

  task automatic test_cfg_midrun();
    logic [6:0] exp;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 288 + 48; k++) begin
      @(negedge clk);
      if (k < 288) exp = model(9, 16, k, (k <= 40 || k >= 285), 1'b1);
      else         exp = model(4, 2, k - 288, 1'b1, 1'b1);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL cfg_midrun k=%0d got=%b exp=%b", k, obs, exp);
      end
      if (k == 40) begin
        cfg_valid = 1'b1; cfg_div = 8'd4; cfg_half = 6'd2;
      end else begin
        cfg_valid = 1'b0;
      end
    end
  endtask

  task automatic test_drain();
    logic [6:0] exp;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 310; k++) begin
      @(negedge clk);
      if (k <= 284) exp = model(9, 16, k, 1'b1, (k < 284));
      else          exp = 7'b1000000;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL drain k=%0d got=%b exp=%b", k, obs, exp);
      end
      if (k == 30) en = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    offer_cfg(8'd4, 6'd2);
    en = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model(4, 2, k, 1'b1, 1'b1)) begin
        failures++;
        $display("FAIL pre_reset k=%0d got=%b exp=%b", k, obs, model(4, 2, k, 1'b1, 1'b1));
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 7'b1000000) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=%b", obs, 7'b1000000);
    end
    reset = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model(9, 16, k, 1'b1, 1'b1)) begin
        failures++;
        $display("FAIL restart k=%0d got=%b exp=%b", k, obs, model(9, 16, k, 1'b1, 1'b1));
      end
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_half = '0;
    test_reset();
    test_defaults();
    test_min_cfg();
    test_clamp();
    test_cfg_midrun();
    test_drain();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
